// File: rtl/cmp_pkg.sv
// Shared types and helpers for the cascaded magnitude comparator.
// Pure declarations: no logic, no latency, no flow control.
package cmp_pkg;

    typedef enum logic [1:0] {
        CMP_EQ = 2'd0,
        CMP_LT = 2'd1,
        CMP_GT = 2'd2
    } cmp_res_t;

    localparam int CMP_SLICE_W_DEFAULT = 4;

    // Flag bundle in {gt, lt, eq} bit order.
    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } cmp_flags_t;

    function automatic cmp_flags_t res_to_flags(input cmp_res_t res);
        cmp_flags_t f;
        f = '0;
        case (res)
            CMP_GT:  f.gt = 1'b1;
            CMP_LT:  f.lt = 1'b1;
            default: f.eq = 1'b1;
        endcase
        return f;
    endfunction

    // A slice never raises more than one flag; anything else collapses to EQ.
    function automatic cmp_res_t flags_to_res(input cmp_flags_t f);
        cmp_res_t r;
        case (f)
            3'b100:  r = CMP_GT;
            3'b010:  r = CMP_LT;
            default: r = CMP_EQ;
        endcase
        return r;
    endfunction

    // Cascade step: the more significant result wins unless it is equal.
    function automatic cmp_res_t res_merge(input cmp_res_t hi, input cmp_res_t lo);
        return (hi == CMP_EQ) ? lo : hi;
    endfunction

endpackage

// File: rtl/comparator_slice.sv
// Purpose: combinational SLICE_W-bit magnitude compare with optional sign-bit inversion.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
module comparator_slice
    import cmp_pkg::*;
#(
    parameter int SLICE_W = CMP_SLICE_W_DEFAULT
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               sign_inv,
    output logic               gt,
    output logic               lt,
    output logic               eq
);

    logic [SLICE_W-1:0] a_k;
    logic [SLICE_W-1:0] b_k;

    // Flipping both top bits maps two's complement ordering onto unsigned ordering.
    always_comb begin
        a_k              = a;
        b_k              = b;
        a_k[SLICE_W-1]   = a[SLICE_W-1] ^ sign_inv;
        b_k[SLICE_W-1]   = b[SLICE_W-1] ^ sign_inv;
    end

    assign gt = (a_k > b_k);
    assign lt = (a_k < b_k);
    assign eq = (a_k == b_k);

endmodule

// File: rtl/comparator_8_bit.sv
// Purpose: registered WIDTH-bit magnitude comparator built from a cascade of slices;
//          COMPARATOR_SIGNED_EN adds a signed_mode input for two's complement compares.
// Latency: 1 cycle (in_valid at edge N -> out_valid/flags after edge N); backpressure: none, one compare per cycle.
module comparator_8_bit
    import cmp_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SLICE_W = CMP_SLICE_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
`ifdef COMPARATOR_SIGNED_EN
    input  logic             signed_mode,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic             A_gt_B,
    output logic             A_lt_B,
    output logic             A_eq_B
);

    localparam int NSLICE = WIDTH / SLICE_W;

    logic       sign_en;
    cmp_res_t   slice_res [NSLICE];
    cmp_res_t   merged;
    cmp_flags_t flags_q;

`ifdef COMPARATOR_SIGNED_EN
    assign sign_en = signed_mode;
`else
    assign sign_en = 1'b0;
`endif

    // Only the most significant slice carries the operand sign bit.
    for (genvar g = 0; g < NSLICE; g++) begin : g_slice
        logic       s_gt;
        logic       s_lt;
        logic       s_eq;
        logic       s_inv;

        assign s_inv = (g == NSLICE - 1) ? sign_en : 1'b0;

        comparator_slice #(
            .SLICE_W (SLICE_W)
        ) u_slice (
            .a        (A[g*SLICE_W +: SLICE_W]),
            .b        (B[g*SLICE_W +: SLICE_W]),
            .sign_inv (s_inv),
            .gt       (s_gt),
            .lt       (s_lt),
            .eq       (s_eq)
        );

        assign slice_res[g] = flags_to_res('{gt: s_gt, lt: s_lt, eq: s_eq});
    end

    always_comb begin
        merged = CMP_EQ;
        for (int i = NSLICE - 1; i >= 0; i--) begin
            merged = res_merge(merged, slice_res[i]);
        end
    end

    // Flags only load on a valid compare, so operands are don't-care otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            flags_q   <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                flags_q <= res_to_flags(merged);
            end
        end
    end

    assign A_gt_B = flags_q.gt;
    assign A_lt_B = flags_q.lt;
    assign A_eq_B = flags_q.eq;

    a_onehot: assert property (@(posedge clk) disable iff (rst)
        out_valid |-> $onehot({A_gt_B, A_lt_B, A_eq_B}));

endmodule

// File: tb/tb_comparator_8_bit.sv
// Directed-vector bench for comparator_8_bit; observed = {out_valid, gt, lt, eq}.
module tb_comparator_8_bit;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] A;
    logic [7:0] B;
`ifdef COMPARATOR_SIGNED_EN
    logic       signed_mode;
`endif
    logic       out_valid;
    logic       A_gt_B;
    logic       A_lt_B;
    logic       A_eq_B;

    int checks;
    int errors;

    logic [3:0] obs;
    assign obs = {out_valid, A_gt_B, A_lt_B, A_eq_B};

    comparator_8_bit #(
        .WIDTH   (8),
        .SLICE_W (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
`ifdef COMPARATOR_SIGNED_EN
        .signed_mode (signed_mode),
`endif
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .A_gt_B    (A_gt_B),
        .A_lt_B    (A_lt_B),
        .A_eq_B    (A_eq_B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs at the falling edge, then step past the next rising edge.
    task automatic apply(input logic r, input logic v, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        A        = a;
        B        = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply(1'b1, 1'b0, 8'h00, 8'h00);
        apply(1'b1, 1'b0, 8'h00, 8'h00);
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state got=%b exp=%b", obs, 4'b0000);
        end
        apply(1'b0, 1'b0, 8'h00, 8'h00);
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("FAIL idle_after_reset got=%b exp=%b", obs, 4'b0000);
        end
    endtask

    task automatic test_equal();
        apply(1'b0, 1'b1, 8'h00, 8'h00);
        checks++;
        if (obs !== 4'b1001) begin
            errors++;
            $display("FAIL eq_00_00 got=%b exp=%b", obs, 4'b1001);
        end
        apply(1'b0, 1'b1, 8'hFF, 8'hFF);
        checks++;
        if (obs !== 4'b1001) begin
            errors++;
            $display("FAIL eq_ff_ff got=%b exp=%b", obs, 4'b1001);
        end
    endtask

    task automatic test_greater();
        apply(1'b0, 1'b1, 8'h99, 8'h66);
        checks++;
        if (obs !== 4'b1100) begin
            errors++;
            $display("FAIL gt_99_66 got=%b exp=%b", obs, 4'b1100);
        end
        apply(1'b0, 1'b1, 8'hFF, 8'h00);
        checks++;
        if (obs !== 4'b1100) begin
            errors++;
            $display("FAIL gt_ff_00 got=%b exp=%b", obs, 4'b1100);
        end
        // Upper nibbles equal, lower slice decides.
        apply(1'b0, 1'b1, 8'h5C, 8'h5B);
        checks++;
        if (obs !== 4'b1100) begin
            errors++;
            $display("FAIL gt_low_slice got=%b exp=%b", obs, 4'b1100);
        end
    endtask

    task automatic test_less();
        apply(1'b0, 1'b1, 8'h33, 8'h44);
        checks++;
        if (obs !== 4'b1010) begin
            errors++;
            $display("FAIL lt_33_44 got=%b exp=%b", obs, 4'b1010);
        end
        apply(1'b0, 1'b1, 8'h00, 8'hFF);
        checks++;
        if (obs !== 4'b1010) begin
            errors++;
            $display("FAIL lt_00_ff got=%b exp=%b", obs, 4'b1010);
        end
        // Upper slice decides even though the lower slice says gt.
        apply(1'b0, 1'b1, 8'h2F, 8'h30);
        checks++;
        if (obs !== 4'b1010) begin
            errors++;
            $display("FAIL lt_high_slice got=%b exp=%b", obs, 4'b1010);
        end
    endtask

    task automatic test_back_to_back();
        apply(1'b0, 1'b1, 8'h10, 8'h0F);
        checks++;
        if (obs !== 4'b1100) begin
            errors++;
            $display("FAIL b2b_gt got=%b exp=%b", obs, 4'b1100);
        end
        apply(1'b0, 1'b1, 8'h0F, 8'h10);
        checks++;
        if (obs !== 4'b1010) begin
            errors++;
            $display("FAIL b2b_lt got=%b exp=%b", obs, 4'b1010);
        end
        apply(1'b0, 1'b1, 8'hA5, 8'hA5);
        checks++;
        if (obs !== 4'b1001) begin
            errors++;
            $display("FAIL b2b_eq got=%b exp=%b", obs, 4'b1001);
        end
    endtask

    task automatic test_hold();
        // Operands are X while idle: flags keep the last eq result.
        apply(1'b0, 1'b0, 8'hxx, 8'hzz);
        checks++;
        if (obs !== 4'b0001) begin
            errors++;
            $display("FAIL hold_1 got=%b exp=%b", obs, 4'b0001);
        end
        apply(1'b0, 1'b0, 8'hx0, 8'h0x);
        checks++;
        if (obs !== 4'b0001) begin
            errors++;
            $display("FAIL hold_2 got=%b exp=%b", obs, 4'b0001);
        end
    endtask

    task automatic test_reset_override();
        apply(1'b0, 1'b1, 8'h80, 8'h01);
        checks++;
        if (obs !== 4'b1100) begin
            errors++;
            $display("FAIL pre_rst_gt got=%b exp=%b", obs, 4'b1100);
        end
        apply(1'b1, 1'b1, 8'h80, 8'h01);
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("FAIL rst_wins got=%b exp=%b", obs, 4'b0000);
        end
        apply(1'b0, 1'b0, 8'h80, 8'h01);
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("FAIL no_stale got=%b exp=%b", obs, 4'b0000);
        end
    endtask

`ifdef COMPARATOR_SIGNED_EN
    task automatic test_signed();
        signed_mode = 1'b1;
        apply(1'b0, 1'b1, 8'h99, 8'h66);
        checks++;
        if (obs !== 4'b1010) begin
            errors++;
            $display("FAIL s_99_66 got=%b exp=%b", obs, 4'b1010);
        end
        apply(1'b0, 1'b1, 8'h80, 8'h7F);
        checks++;
        if (obs !== 4'b1010) begin
            errors++;
            $display("FAIL s_80_7f got=%b exp=%b", obs, 4'b1010);
        end
        apply(1'b0, 1'b1, 8'hFF, 8'hFE);
        checks++;
        if (obs !== 4'b1100) begin
            errors++;
            $display("FAIL s_ff_fe got=%b exp=%b", obs, 4'b1100);
        end
        @(negedge clk);
        signed_mode = 1'b0;
        apply(1'b0, 1'b1, 8'h80, 8'h7F);
        checks++;
        if (obs !== 4'b1100) begin
            errors++;
            $display("FAIL u_80_7f got=%b exp=%b", obs, 4'b1100);
        end
    endtask
`endif

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        A        = 8'h00;
        B        = 8'h00;
`ifdef COMPARATOR_SIGNED_EN
        signed_mode = 1'b0;
`endif
        test_reset();
        test_equal();
        test_greater();
        test_less();
        test_back_to_back();
        test_hold();
        test_reset_override();
`ifdef COMPARATOR_SIGNED_EN
        test_signed();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
